// File: rtl/core85_pkg.sv
// Shared core85 constants: register/pair indices, flag mask and the
// stack sequencer state encoding.
package core85_pkg;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_F = 3'd6;
  localparam logic [2:0] REG_A = 3'd7;

  localparam logic [1:0] REGP_BC = 2'd0;
  localparam logic [1:0] REGP_DE = 2'd1;
  localparam logic [1:0] REGP_HL = 2'd2;
  localparam logic [1:0] REGP_SP = 2'd3;

  localparam logic [7:0] FLAGMASK = 8'b1101_0101;

  typedef enum logic [1:0] {IDLE, XFER1, XFER2, FIN} seq_state_t;

endpackage

// File: rtl/regpair_stack_if.sv
// Byte-wide memory bus with req/ack handshake between the stack sequencer
// and the memory interface.
interface regpair_stack_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16
);
  logic                req;
  logic                wr;
  logic [ADDRSIZE-1:0] addr;
  logic [DATASIZE-1:0] wdata;
  logic [DATASIZE-1:0] rdata;
  logic                ack;

  modport master (output req, wr, addr, wdata, input rdata, ack);
  modport slave  (input req, wr, addr, wdata, output rdata, ack);
endinterface

// File: rtl/stack_seq.sv
// PUSH/POP sequencer: owns SP and moves one register pair over the byte bus,
// high byte at SP-1 / SP+1, low byte at SP-2 / SP.
module stack_seq
  import core85_pkg::*;
#(
  parameter int                  DATASIZE = 8,
  parameter int                  ADDRSIZE = 16,
  parameter int                  REGSBITS = 3,
  parameter logic [ADDRSIZE-1:0] SP_INIT  = '1
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                op_valid,
  input  logic                op_push,
  input  logic [REGSBITS-2:0] op_pair,
  output logic                op_ready,
  output logic                done,
  output logic [ADDRSIZE-1:0] sp_out,
  output logic [REGSBITS-2:0] cur_pair,
  input  logic [ADDRSIZE-1:0] cur_data,
  output logic                pop_we,
  output logic [REGSBITS-1:0] pop_idx,
  output logic [DATASIZE-1:0] pop_data,
  regpair_stack_if.master     mem
);

  seq_state_t          state_q, state_d;
  logic                push_q;
  logic [REGSBITS-2:0] pair_q;
  logic [ADDRSIZE-1:0] sp_q;

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
      pair_q  <= '0;
      sp_q    <= SP_INIT;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && op_valid) begin
        push_q <= op_push;
        pair_q <= op_pair;
      end
      // SP moves only once both bytes are on the bus, so an abort leaves it intact
      if (state_q == FIN)
        sp_q <= push_q ? sp_q - ADDRSIZE'(2) : sp_q + ADDRSIZE'(2);
    end
  end

  always_comb begin
    state_d   = state_q;
    mem.req   = 1'b0;
    mem.wr    = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    done      = 1'b0;
    pop_we    = 1'b0;
    pop_idx   = {pair_q, 1'b1};
    case (state_q)
      IDLE: if (op_valid) state_d = XFER1;
      XFER1: begin
        mem.req   = 1'b1;
        mem.wr    = push_q;
        mem.addr  = push_q ? sp_q - ADDRSIZE'(1) : sp_q;
        mem.wdata = push_q ? cur_data[ADDRSIZE-1 -: DATASIZE] : '0;
        if (mem.ack) begin
          state_d = XFER2;
          pop_we  = !push_q;
        end
      end
      XFER2: begin
        mem.req   = 1'b1;
        mem.wr    = push_q;
        mem.addr  = push_q ? sp_q - ADDRSIZE'(2) : sp_q + ADDRSIZE'(1);
        mem.wdata = push_q ? cur_data[DATASIZE-1:0] : '0;
        pop_idx   = {pair_q, 1'b0};
        if (mem.ack) begin
          state_d = FIN;
          pop_we  = !push_q;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_ready = (state_q == IDLE);
  assign sp_out   = sp_q;
  assign cur_pair = pair_q;
  assign pop_data = mem.rdata;

endmodule

// File: rtl/regpair_stack.sv
// core85 register bank: byte registers, pair inc/dec and the stack sequencer.
// Pair p is {reg[2p], reg[2p+1]}; ADDRSIZE must equal 2*DATASIZE.
module regpair_stack #(
  parameter int                  DATASIZE = 8,
  parameter int                  ADDRSIZE = 16,
  parameter int                  REGSBITS = 3,
  parameter logic [ADDRSIZE-1:0] SP_INIT  = 16'hFFFF,
  parameter int                  FLAG_IDX = 6,
  parameter logic [DATASIZE-1:0] FLAGMASK = core85_pkg::FLAGMASK
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                wr_en,
  input  logic [REGSBITS-1:0] wr_addr,
  input  logic [DATASIZE-1:0] wr_data,
  input  logic [REGSBITS-1:0] rd_addr_a,
  input  logic [REGSBITS-1:0] rd_addr_b,
  output logic [DATASIZE-1:0] rd_data_a,
  output logic [DATASIZE-1:0] rd_data_b,
  input  logic [REGSBITS-2:0] rp_sel,
  output logic [ADDRSIZE-1:0] rp_data,
  input  logic                rp_inc,
  input  logic                rp_dec,
  input  logic                op_valid,
  input  logic                op_push,
  input  logic [REGSBITS-2:0] op_pair,
  output logic                op_ready,
  output logic                done,
  output logic [ADDRSIZE-1:0] sp_out,
  regpair_stack_if.master     mem
);

  localparam int REGCOUNT = 2**REGSBITS;

  logic [REGCOUNT-1:0][DATASIZE-1:0] regs;
  logic [REGSBITS-2:0]               cur_pair;
  logic [ADDRSIZE-1:0]               cur_data;
  logic                              pop_we;
  logic [REGSBITS-1:0]               pop_idx;
  logic [DATASIZE-1:0]               pop_data, pop_val;
  logic                              pair_op;
  logic [ADDRSIZE-1:0]               rp_next;

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign rp_data   = {regs[{rp_sel, 1'b0}], regs[{rp_sel, 1'b1}]};
  assign cur_data  = {regs[{cur_pair, 1'b0}], regs[{cur_pair, 1'b1}]};

  // Simultaneous inc and dec cancel; nothing from the control unit lands while busy
  assign pair_op = op_ready & (rp_inc ^ rp_dec);
  assign rp_next = rp_inc ? rp_data + ADDRSIZE'(1) : rp_data - ADDRSIZE'(1);
  assign pop_val = (int'(pop_idx) == FLAG_IDX) ? (pop_data & FLAGMASK) : pop_data;

  always_ff @(posedge clk) begin
    if (rst_) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < REGCOUNT; i++) begin
        if (pop_we && pop_idx == REGSBITS'(i))
          regs[i] <= pop_val;
        else if (pair_op && rp_sel == (REGSBITS-1)'(i / 2))
          regs[i] <= ((i % 2) == 0) ? rp_next[ADDRSIZE-1 -: DATASIZE] : rp_next[DATASIZE-1:0];
        else if (op_ready && wr_en && wr_addr == REGSBITS'(i))
          regs[i] <= wr_data;
      end
    end
  end

  stack_seq #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE),
    .REGSBITS (REGSBITS),
    .SP_INIT  (SP_INIT)
  ) u_seq (
    .clk      (clk),
    .rst_     (rst_),
    .op_valid (op_valid),
    .op_push  (op_push),
    .op_pair  (op_pair),
    .op_ready (op_ready),
    .done     (done),
    .sp_out   (sp_out),
    .cur_pair (cur_pair),
    .cur_data (cur_data),
    .pop_we   (pop_we),
    .pop_idx  (pop_idx),
    .pop_data (pop_data),
    .mem      (mem)
  );

endmodule

// File: tb/tb_regpair_stack.sv
// Bench for regpair_stack: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of registers, SP and memory.
module tb_regpair_stack;
  import core85_pkg::*;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 0, rp_inc = 0, rp_dec = 0, op_valid = 0, op_push = 0;
  logic [2:0] wr_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic [7:0] wr_data = 0, rd_data_a, rd_data_b;
  logic [1:0] rp_sel = 0, op_pair = 0;
  logic [15:0] rp_data, sp_out;
  logic       op_ready, done;

  regpair_stack_if #(.DATASIZE(8), .ADDRSIZE(16)) mem ();

  regpair_stack dut (
    .clk(clk), .rst_(rst_), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rp_sel(rp_sel), .rp_data(rp_data), .rp_inc(rp_inc), .rp_dec(rp_dec),
    .op_valid(op_valid), .op_push(op_push), .op_pair(op_pair), .op_ready(op_ready),
    .done(done), .sp_out(sp_out), .mem(mem)
  );

  logic [7:0] mem_arr [0:65535];
  assign mem.rdata = mem_arr[mem.addr];

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_regs [8];
  logic [15:0] m_sp;
  bit          m_busy, m_push;
  logic [1:0]  m_pair;
  int          m_step;   // 0,1 = byte transfer number, 2 = completing

  function automatic logic [15:0] pairv(input logic [1:0] p);
    return {m_regs[{p, 1'b0}], m_regs[{p, 1'b1}]};
  endfunction
  function automatic logic [15:0] exp_addr();
    return m_push ? m_sp - 16'(1 + m_step) : m_sp + 16'(m_step);
  endfunction
  function automatic logic [7:0] exp_wdata();
    return (m_step == 0) ? m_regs[{m_pair, 1'b0}] : m_regs[{m_pair, 1'b1}];
  endfunction

  always @(posedge clk) begin
    logic [15:0] pv;
    logic [7:0]  d;
    logic [2:0]  idx;
    if (rst_) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_sp = 16'hFFFF;
      m_busy = 0;
      m_step = 0;
    end else if (!m_busy) begin
      pv = pairv(rp_sel);
      if (wr_en) m_regs[wr_addr] = wr_data;
      if (rp_inc != rp_dec) begin
        pv = rp_inc ? pv + 16'd1 : pv - 16'd1;
        m_regs[{rp_sel, 1'b0}] = pv[15:8];
        m_regs[{rp_sel, 1'b1}] = pv[7:0];
      end
      if (op_valid) begin
        m_busy = 1; m_push = op_push; m_pair = op_pair; m_step = 0;
      end
    end else if (m_step == 2) begin
      m_sp = m_push ? m_sp - 16'd2 : m_sp + 16'd2;
      m_busy = 0;
    end else if (mem.ack) begin
      if (m_push) mem_arr[exp_addr()] = exp_wdata();
      else begin
        idx = {m_pair, (m_step == 0) ? 1'b1 : 1'b0};
        d = mem_arr[exp_addr()];
        if (idx == 3'd6) d = d & 8'hD5;
        m_regs[idx] = d;
      end
      m_step++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) if (chk_en) begin
    chk("sp_out", sp_out, m_sp);
    chk("op_ready", op_ready, !m_busy);
    chk("done", done, m_busy && m_step == 2);
    chk("mem_req", mem.req, m_busy && m_step < 2);
    if (m_busy && m_step < 2) begin
      chk("mem_wr", mem.wr, m_push);
      chk("mem_addr", mem.addr, exp_addr());
      if (m_push) chk("mem_wdata", mem.wdata, exp_wdata());
    end
    chk("rd_data_a", rd_data_a, m_regs[rd_addr_a]);
    chk("rd_data_b", rd_data_b, m_regs[rd_addr_b]);
    chk("rp_data", rp_data, pairv(rp_sel));
  end

  // ---------------- memory responder ----------------
  int ack_cfg = 0, cur_wait = 0, wcnt = 0;
  bit stray = 0;
  initial mem.ack = 1'b0;
  always @(negedge clk) begin
    #2;
    if (mem.req) begin
      if (wcnt >= cur_wait) begin
        mem.ack = 1'b1; wcnt = 0;
        cur_wait = (ack_cfg < 0) ? int'($urandom_range(0, 2)) : ack_cfg;
      end else begin
        mem.ack = 1'b0; wcnt++;
      end
    end else begin
      mem.ack = stray && ($urandom % 3 == 0);
      wcnt = 0;
      cur_wait = (ack_cfg < 0) ? int'($urandom_range(0, 2)) : ack_cfg;
    end
  end

  // write transfers as seen on the bus
  int ncap = 0;
  logic [15:0] cap_addr [4];
  logic [7:0]  cap_data [4];
  always @(posedge clk) if (mem.req && mem.ack && mem.wr && ncap < 4) begin
    cap_addr[ncap] = mem.addr; cap_data[ncap] = mem.wdata; ncap++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] v);
    wr_en = 1; wr_addr = a; wr_data = v; tick(); wr_en = 0;
  endtask

  task automatic issue(input logic push, input logic [1:0] p);
    op_valid = 1; op_push = push; op_pair = p; tick(); op_valid = 0;
  endtask

  task automatic wait_idle(output int nd);
    int cyc;
    nd = 0; cyc = 0;
    while (!op_ready && cyc < 40) begin
      if (done) nd++;
      tick(); cyc++;
    end
    if (!op_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: op_ready=0 after %0d cycles, required 1", cyc);
    end
  endtask

  initial begin
    int nd, cyc;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
    chk_en = 1;
    rst_ = 1; repeat (2) tick(); rst_ = 0;

    // reset state
    rd_addr_a = REG_B; rd_addr_b = REG_A; #1;
    chk("rst sp_out", sp_out, 16'hFFFF);
    chk("rst rd_a", rd_data_a, 8'h00);
    chk("rst rd_b", rd_data_b, 8'h00);
    chk("rst mem_req", mem.req, 1'b0);
    chk("rst mem_addr", mem.addr, 16'h0000);
    chk("rst op_ready", op_ready, 1'b1);
    chk("rst done", done, 1'b0);

    // pair wrap
    wr_reg(REG_B, 8'hFF); wr_reg(REG_C, 8'hFF);
    rp_sel = REGP_BC; rp_inc = 1; tick(); rp_inc = 0;
    chk("inc wrap", rp_data, 16'h0000);
    rp_dec = 1; tick(); rp_dec = 0;
    chk("dec wrap", rp_data, 16'hFFFF);
    rp_inc = 1; rp_dec = 1; tick(); rp_inc = 0; rp_dec = 0;
    chk("inc+dec noop", rp_data, 16'hFFFF);

    // PUSH DE with two wait cycles per byte, plus busy lockout
    wr_reg(REG_D, 8'h12); wr_reg(REG_E, 8'h34);
    ack_cfg = 2; ncap = 0;
    issue(1'b1, REGP_DE);
    wr_en = 1; wr_addr = REG_B; wr_data = 8'h55;
    op_valid = 1; op_push = 0; op_pair = REGP_HL;
    tick(); wr_en = 0; op_valid = 0;
    wait_idle(nd);
    chk("push ncap", ncap, 2);
    chk("push addr0", cap_addr[0], 16'hFFFE);
    chk("push data0", cap_data[0], 8'h12);
    chk("push addr1", cap_addr[1], 16'hFFFD);
    chk("push data1", cap_data[1], 8'h34);
    chk("push sp", sp_out, 16'hFFFD);
    chk("push done count", nd, 1);
    rd_addr_a = REG_B; #1;
    chk("lockout B", rd_data_a, 8'hFF);
    repeat (3) tick();
    chk("lockout no op", sp_out, 16'hFFFD);
    chk("lockout ready", op_ready, 1'b1);

    // POP into flags, ack in first req cycle: pins the 3-cycle latency
    mem_arr[16'hFFFD] = 8'hFF; mem_arr[16'hFFFE] = 8'hAB;
    ack_cfg = 0;
    issue(1'b0, REGP_SP);
    chk("pop xfer1 req", mem.req, 1'b1);
    chk("pop xfer1 addr", mem.addr, 16'hFFFD);
    tick();
    chk("pop xfer2 addr", mem.addr, 16'hFFFE);
    tick();
    chk("pop fin done", done, 1'b1);
    chk("pop fin req", mem.req, 1'b0);
    tick();
    chk("pop ready back", op_ready, 1'b1);
    rd_addr_a = REG_F; rd_addr_b = REG_A; #1;
    chk("pop flags masked", rd_data_a, 8'h81);
    chk("pop lo", rd_data_b, 8'hFF);
    chk("pop sp", sp_out, 16'hFFFF);

    // reset while in XFER2 of a POP
    wr_reg(REG_H, 8'h77);
    mem_arr[16'hFFFF] = 8'h3C; mem_arr[16'h0000] = 8'h5A;
    ack_cfg = 3;
    rd_addr_a = REG_L; rd_addr_b = REG_H;
    issue(1'b0, REGP_HL);
    cyc = 0;
    while (rd_data_a != 8'h3C && cyc < 20) begin tick(); cyc++; end
    chk("midop lo written", rd_data_a, 8'h3C);
    chk("midop hi untouched", rd_data_b, 8'h77);
    chk("midop in xfer2", mem.req, 1'b1);
    chk("midop addr wrap", mem.addr, 16'h0000);
    rst_ = 1; tick(); rst_ = 0;
    chk("abort req", mem.req, 1'b0);
    chk("abort sp", sp_out, 16'hFFFF);
    chk("abort ready", op_ready, 1'b1);
    chk("abort regs", rd_data_b, 8'h00);

    // random traffic
    ack_cfg = -1; stray = 1;
    for (int n = 0; n < 3000; n++) begin
      rst_      = ($urandom % 400 == 0);
      wr_en     = ($urandom % 3 == 0);
      wr_addr   = 3'($urandom);
      wr_data   = 8'($urandom);
      rd_addr_a = 3'($urandom);
      rd_addr_b = 3'($urandom);
      rp_sel    = 2'($urandom);
      rp_inc    = ($urandom % 5 == 0);
      rp_dec    = ($urandom % 5 == 0);
      op_valid  = ($urandom % 4 == 0);
      op_push   = 1'($urandom);
      op_pair   = 2'($urandom);
      tick();
    end
    rst_ = 0; wr_en = 0; rp_inc = 0; rp_dec = 0; op_valid = 0; stray = 0;
    wait_idle(nd);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
